mux_nx1_reg: RTL and testbench
==============================

# mux_nx1_reg

Parametrised, registered N:1 datapath multiplexer with per-input valid/ready handshake. It is the successor to the fixed 16-bit 2:1 bit-sliced mux used in the processor datapath. It generalises data width and input count, and adds a one-entry output register, backpressure, and a selectable round-robin arbitration mode. It sits between multiple producers (ALU, load unit, immediate path) and a single consumer such as the writeback port.

## Interface
- WIDTH, 16, data width per input in bits (≥1)
- NUM_IN, 4, number of inputs (2..16)
- SEL_W, 2, width of sel/grant_idx; must satisfy 2^SEL_W ≥ NUM_IN

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  NUM_IN*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NUM_IN  input i holds a valid word
- in_ready  output  NUM_IN  combinational; one-hot or zero; input i's word is consumed this cycle
- sel  input  SEL_W  input index used when mode=0
- mode  input  1  0 = fixed select by sel; 1 = round-robin over valid inputs
- out_data  output  WIDTH  registered selected word
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data this cycle
- grant_idx  output  SEL_W  registered index of the input that supplied out_data

## Operation
- load_en = !out_valid || out_ready; the output register may load only when empty or being drained the same cycle.
- Candidate selection (combinational):
  - mode=0: the candidate is sel when sel < NUM_IN and in_valid[sel]=1; otherwise there is no candidate. An out-of-range sel never grants.
  - mode=1: search indices rr_ptr, rr_ptr+1, … mod NUM_IN. The first index with in_valid set is the candidate.
- Grant: if load_en and a candidate c exists, then in_ready[c]=1 and all other bits are 0. Otherwise in_ready is all zeros.
- On grant at the clock edge:
  - out_data ← in_data[c]
  - grant_idx ← c
  - out_valid ← 1
  - in mode=1 only, rr_ptr ← (c+1) mod NUM_IN
- No grant while load_en=1: out_valid ← 0 if out_ready drained it. out_data and grant_idx hold.
- Stall (out_valid=1, out_ready=0): all outputs hold. in_ready is 0.
- rr_ptr is internal, SEL_W bits, range 0..NUM_IN-1. It is untouched in mode=0 and when there is no grant.
- Mode switches take effect on the next grant decision. rr_ptr keeps its value across switches.
- Producers must hold in_data/in_valid stable until in_ready is seen; the block does not buffer ungranted inputs.

## Timing
- Reset values: out_valid=0, out_data=0, grant_idx=0, rr_ptr=0. in_ready=0 while rst=1.
- Reset mid-transfer discards the held word. There is no grant in the reset cycle.
- Latency: 1 cycle from the grant cycle (in_ready[c]=1) to out_valid=1 with the word.
- Throughput: 1 word/cycle when out_ready is held high. A simultaneous drain and load is a single-cycle replace with no bubble.
- in_ready depends combinationally on in_valid, sel, mode, out_valid, out_ready, and rr_ptr. It has no dependency on in_data.
- The out_valid/out_data pair never changes while out_valid=1 and out_ready=0.

## Test plan
- Reset: assert rst for 2 cycles with all in_valid=1. Required: in_ready=0 during reset; after release, out_valid=0, out_data=0, grant_idx=0.
- Fixed select, WIDTH=16, NUM_IN=4, mode=0, sel=2, in_data[2]=0xBEEF, in_valid=4'b0100, out_ready=1. Required: in_ready=4'b0100 in cycle N; next cycle out_data=0xBEEF, out_valid=1, grant_idx=2. Then sel=3 with in_valid[3]=0: in_ready=0 and out_valid drops the following cycle.
- Backpressure: hold out_ready=0 with out_valid=1 for 5 cycles while inputs change. Required: in_ready=0, out_data/grant_idx unchanged. On the out_ready=1 cycle, a new grant occurs and the new word appears the next cycle with no bubble.
- Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1 for 8 cycles. Required: grant_idx sequence 0,1,2,3,0,1,2,3.
- Round-robin wrap/skip: mode=1, rr_ptr=3, in_valid=4'b0010. Required: grant 1, then rr_ptr=2. Then in_valid=4'b0101 gives grant 2, then grant 0.
- Out-of-range select and mode switch: NUM_IN=3, SEL_W=2, mode=0, sel=3, all valid. Required: no grant. Then switching to mode=1 grants index rr_ptr on the next cycle, with rr_ptr preserved from before mode=0.

Source files
------------

// File: rtl/mux_nx1_reg.sv
// mux_nx1_reg
// Registered N:1 datapath multiplexer with a per-input valid/ready handshake,
// a one-entry output register with backpressure, and two arbitration modes:
// fixed select by 'sel' (mode=0) or round-robin over valid inputs (mode=1).
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_data    packed input words, input i at [i*WIDTH +: WIDTH]
//   in_valid   per-input valid
//   in_ready   per-input consume strobe (combinational, one-hot or zero)
//   sel        input index used in fixed-select mode
//   mode       0 = fixed select, 1 = round-robin
//   out_data   registered selected word
//   out_valid  out_data holds a word
//   out_ready  consumer takes out_data this cycle
//   grant_idx  registered index of the input that supplied out_data
module mux_nx1_reg #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        grant_idx
);

  // Every index representable in SEL_W bits gets a slot; slots past NUM_IN
  // read as "never valid", which makes an out-of-range sel simply not grant.
  localparam int SLOTS = 1 << SEL_W;

  logic [WIDTH-1:0] word_slot [SLOTS];
  logic [SLOTS-1:0] valid_slot;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < NUM_IN) begin : g_used
        assign word_slot[gi]  = in_data[gi*WIDTH +: WIDTH];
        assign valid_slot[gi] = in_valid[gi];
      end else begin : g_pad
        assign word_slot[gi]  = '0;
        assign valid_slot[gi] = 1'b0;
      end
    end
  endgenerate

  logic [WIDTH-1:0] out_data_reg,  out_data_next;
  logic             out_valid_reg, out_valid_next;
  logic [SEL_W-1:0] grant_idx_reg, grant_idx_next;
  logic [SEL_W-1:0] rr_ptr_reg,    rr_ptr_next;

  logic             load_en;
  logic             grant;
  logic             cand_found;
  logic [SEL_W-1:0] cand_idx;
  logic [SEL_W:0]   rr_sum;
  logic [SEL_W-1:0] rr_after;

  // The output register can accept a word when empty or being drained now.
  assign load_en = !out_valid_reg || out_ready;

  // Candidate search. In round-robin mode the search starts at rr_ptr and
  // wraps modulo NUM_IN; the first valid index wins.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    rr_sum     = '0;
    if (!mode) begin
      if (valid_slot[sel]) begin
        cand_found = 1'b1;
        cand_idx   = sel;
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        rr_sum = {1'b0, rr_ptr_reg} + (SEL_W+1)'(k);
        if (rr_sum >= (SEL_W+1)'(NUM_IN)) begin
          rr_sum = rr_sum - (SEL_W+1)'(NUM_IN);
        end
        if (!cand_found && valid_slot[rr_sum[SEL_W-1:0]]) begin
          cand_found = 1'b1;
          cand_idx   = rr_sum[SEL_W-1:0];
        end
      end
    end
  end

  // No grant is ever issued in a reset cycle.
  assign grant = load_en && cand_found && !rst;

  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_ready
      assign in_ready[gi] = grant && (cand_idx == SEL_W'(gi));
    end
  endgenerate

  // Pointer value following the granted index, wrapping at NUM_IN.
  assign rr_after = (cand_idx == SEL_W'(NUM_IN - 1)) ? '0 : cand_idx + SEL_W'(1);

  always_comb begin
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    grant_idx_next = grant_idx_reg;
    rr_ptr_next    = rr_ptr_reg;
    if (grant) begin
      out_data_next  = word_slot[cand_idx];
      grant_idx_next = cand_idx;
      out_valid_next = 1'b1;
      if (mode) begin
        rr_ptr_next = rr_after;
      end
    end else if (load_en) begin
      // Drained (or already empty) with nothing to replace it.
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      grant_idx_reg <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      grant_idx_reg <= grant_idx_next;
      rr_ptr_reg    <= rr_ptr_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign grant_idx = grant_idx_reg;

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Bench for mux_nx1_reg: one 4-input instance (a) and one 3-input instance (b)
// sharing clock and reset, both checked every cycle against a behavioural model.
module tb_mux_nx1_reg;

  logic clk;
  logic rst;

  // Instance a: WIDTH=16, NUM_IN=4, SEL_W=2
  logic [15:0] a_word [4];
  logic [63:0] a_in_data;
  logic [3:0]  a_in_valid;
  logic [3:0]  a_in_ready;
  logic [1:0]  a_sel;
  logic        a_mode;
  logic [15:0] a_out_data;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [1:0]  a_grant_idx;

  // Instance b: WIDTH=16, NUM_IN=3, SEL_W=2 (sel=3 is out of range)
  logic [15:0] b_word [3];
  logic [47:0] b_in_data;
  logic [2:0]  b_in_valid;
  logic [2:0]  b_in_ready;
  logic [1:0]  b_sel;
  logic        b_mode;
  logic [15:0] b_out_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [1:0]  b_grant_idx;

  assign a_in_data = {a_word[3], a_word[2], a_word[1], a_word[0]};
  assign b_in_data = {b_word[2], b_word[1], b_word[0]};

  mux_nx1_reg #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .sel(a_sel), .mode(a_mode),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .grant_idx(a_grant_idx)
  );

  mux_nx1_reg #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sel(b_sel), .mode(b_mode),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .grant_idx(b_grant_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Behavioural model state, index 0 = instance a, 1 = instance b.
  bit          m_ov [2];
  logic [15:0] m_od [2];
  int          m_gi [2];
  int          m_rr [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which input would be taken, derived straight from the selection rules.
  function automatic void pick(input logic [3:0] v, input int s, input logic m,
                               input int rr, input int n, output bit f, output int c);
    f = 0;
    c = 0;
    if (!m) begin
      if (s < n && v[s]) begin
        f = 1;
        c = s;
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        int i;
        i = (rr + k) % n;
        if (!f && v[i]) begin
          f = 1;
          c = i;
        end
      end
    end
  endfunction

  task automatic model_edge(input int inst, input bit load, input bit f, input int c,
                            input logic [15:0] w, input logic m, input int n);
    if (load && f) begin
      m_od[inst] = w;
      m_gi[inst] = c;
      m_ov[inst] = 1;
      if (m) m_rr[inst] = (c + 1) % n;
    end else if (load) begin
      m_ov[inst] = 0;
    end
  endtask

  // One clock cycle: check in_ready mid-cycle, advance the model at the edge,
  // then check registered outputs 1 time unit after the edge.
  task automatic cyc(input string tag);
    bit fa, fb, la, lb;
    int ca, cb;
    logic [3:0] ea;
    logic [2:0] eb;
    #1;
    la = !m_ov[0] || a_out_ready;
    lb = !m_ov[1] || b_out_ready;
    pick(a_in_valid, int'(a_sel), a_mode, m_rr[0], 4, fa, ca);
    pick({1'b0, b_in_valid}, int'(b_sel), b_mode, m_rr[1], 3, fb, cb);
    ea = (!rst && la && fa) ? 4'(1 << ca) : 4'b0;
    eb = (!rst && lb && fb) ? 3'(1 << cb) : 3'b0;
    check({tag, " a.in_ready"}, 32'(a_in_ready), 32'(ea));
    check({tag, " b.in_ready"}, 32'(b_in_ready), 32'(eb));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_ov[i] = 0; m_od[i] = '0; m_gi[i] = 0; m_rr[i] = 0;
      end
    end else begin
      model_edge(0, la, fa, ca, a_word[ca], a_mode, 4);
      model_edge(1, lb, fb, cb, b_word[cb], b_mode, 3);
    end
    #1;
    check({tag, " a.out_valid"}, 32'(a_out_valid), 32'(m_ov[0]));
    check({tag, " a.out_data"},  32'(a_out_data),  32'(m_od[0]));
    check({tag, " a.grant_idx"}, 32'(a_grant_idx), 32'(m_gi[0]));
    check({tag, " b.out_valid"}, 32'(b_out_valid), 32'(m_ov[1]));
    check({tag, " b.out_data"},  32'(b_out_data),  32'(m_od[1]));
    check({tag, " b.grant_idx"}, 32'(b_grant_idx), 32'(m_gi[1]));
    $display("cycle %s: a rdy=%b ov=%0d od=%h gi=%0d | b rdy=%b ov=%0d od=%h gi=%0d",
             tag, a_in_ready, a_out_valid, a_out_data, a_grant_idx,
             b_in_ready, b_out_valid, b_out_data, b_grant_idx);
  endtask

  initial begin
    logic [15:0] held_data;
    for (int i = 0; i < 2; i++) begin
      m_ov[i] = 0; m_od[i] = '0; m_gi[i] = 0; m_rr[i] = 0;
    end
    for (int i = 0; i < 4; i++) a_word[i] = 16'(16'h1000 + i);
    for (int i = 0; i < 3; i++) b_word[i] = 16'(16'h2000 + i);

    // Reset with every input valid: nothing may be granted.
    rst = 1; a_in_valid = 4'b1111; b_in_valid = 3'b111;
    a_sel = 0; b_sel = 0; a_mode = 0; b_mode = 0;
    a_out_ready = 1; b_out_ready = 1;
    cyc("reset0");
    cyc("reset1");
    rst = 0; a_in_valid = 4'b0000; b_in_valid = 3'b000;
    cyc("post_reset");
    check("post_reset out_valid", 32'(a_out_valid), 32'd0);
    check("post_reset out_data", 32'(a_out_data), 32'd0);

    // Fixed select of input 2.
    a_sel = 2; a_word[2] = 16'hBEEF; a_in_valid = 4'b0100;
    cyc("fixed_sel2");
    check("fixed out_data", 32'(a_out_data), 32'h0000BEEF);
    check("fixed grant_idx", 32'(a_grant_idx), 32'd2);
    a_sel = 3;
    cyc("fixed_sel3_invalid");
    check("fixed drop out_valid", 32'(a_out_valid), 32'd0);

    // Backpressure: load one word, then stall for 5 cycles with changing inputs.
    a_sel = 1; a_word[1] = 16'h1234; a_in_valid = 4'b0010;
    cyc("bp_load");
    held_data = a_out_data;
    a_out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      a_in_valid = 4'($urandom_range(0, 15)); a_sel = 2'($urandom);
      a_word[a_sel] = 16'($urandom);
      cyc("bp_stall");
      check("bp held data", 32'(a_out_data), 32'(held_data));
    end
    a_out_ready = 1; a_sel = 0; a_word[0] = 16'hCAFE; a_in_valid = 4'b0001;
    cyc("bp_release");
    check("bp no bubble", 32'(a_out_data), 32'h0000CAFE);

    // Round-robin fairness from rr_ptr=0.
    a_mode = 1; a_in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      cyc("rr_fair");
      check("rr sequence", 32'(a_grant_idx), 32'(k % 4));
    end

    // Move rr_ptr to 3, then wrap/skip.
    a_in_valid = 4'b0100;
    cyc("rr_set_ptr3");
    a_in_valid = 4'b0010;
    cyc("rr_wrap");
    check("rr wrap grant", 32'(a_grant_idx), 32'd1);
    a_in_valid = 4'b0101;
    cyc("rr_skip_a");
    check("rr skip grant2", 32'(a_grant_idx), 32'd2);
    cyc("rr_skip_b");
    check("rr skip grant0", 32'(a_grant_idx), 32'd0);
    a_in_valid = 4'b0000;

    // 3-input instance: out-of-range sel, then mode switch keeps rr_ptr.
    b_mode = 1; b_in_valid = 3'b001;
    cyc("b_rr_ptr1");
    b_mode = 0; b_sel = 3; b_in_valid = 3'b111;
    for (int k = 0; k < 3; k++) begin
      cyc("b_sel_oob");
      check("b oob no grant", 32'(b_out_valid), 32'd0);
    end
    b_mode = 1;
    cyc("b_mode_switch");
    check("b switch grant", 32'(b_grant_idx), 32'd1);

    // Random traffic on both instances.
    for (int k = 0; k < 300; k++) begin
      a_in_valid = 4'($urandom); a_sel = 2'($urandom); a_mode = 1'($urandom);
      a_out_ready = ($urandom_range(0, 9) < 7);
      b_in_valid = 3'($urandom); b_sel = 2'($urandom); b_mode = 1'($urandom);
      b_out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 4; i++) a_word[i] = 16'($urandom);
      for (int i = 0; i < 3; i++) b_word[i] = 16'($urandom);
      rst = (k == 150);
      cyc("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
